// File: rtl/stage_id_scoreboard_pkg.sv
// Shared types for the ID-stage register scoreboard.
package stage_id_scoreboard_pkg;
  localparam int REG_COUNT  = 32;
  localparam int LAT_W      = 3;
  localparam int WB_PORTS   = 2;
  localparam int REG_ADDR_W = $clog2(REG_COUNT);

  typedef logic [REG_ADDR_W-1:0] RegAddr;
  typedef logic [LAT_W-1:0]      ScoreLat;

  localparam ScoreLat SCORE_LAT_VAR = '0;
endpackage

// File: rtl/stage_id_scoreboard_if.sv
// Issue / writeback / status bundle between the ID stage and the scoreboard.
interface stage_id_scoreboard_if;
  import stage_id_scoreboard_pkg::*;

  logic                    i_issValid;
  RegAddr                  i_issRS1;
  RegAddr                  i_issRS2;
  logic                    i_issUseRS1;
  logic                    i_issUseRS2;
  RegAddr                  i_issRD;
  ScoreLat                 i_issLat;
  logic                    i_stall;
  logic [WB_PORTS-1:0]     i_wbValid;
  RegAddr [WB_PORTS-1:0]   i_wbAddr;
  logic                    o_hazard;
  logic                    o_issAccept;
  logic [REG_COUNT-1:0]    o_busyMask;

  modport master (
    output i_issValid, i_issRS1, i_issRS2, i_issUseRS1, i_issUseRS2,
    output i_issRD, i_issLat, i_stall, i_wbValid, i_wbAddr,
    input  o_hazard, o_issAccept, o_busyMask
  );

  modport slave (
    input  i_issValid, i_issRS1, i_issRS2, i_issUseRS1, i_issUseRS2,
    input  i_issRD, i_issLat, i_stall, i_wbValid, i_wbAddr,
    output o_hazard, o_issAccept, o_busyMask
  );
endinterface

// File: rtl/stage_id_scoreboard_entry.sv
// One scoreboard slot: busy flag plus fixed-latency countdown or wait-for-writeback mode.
module scoreboard_entry
  import stage_id_scoreboard_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    issue_hit,
  input  ScoreLat lat,
  input  logic    clear_hit,
  output logic    busy
);

  logic    is_var;
  ScoreLat cnt;

  // The issue edge already counts as the first elapsed cycle, so a fixed producer
  // loads lat-1 and a latency-1 result is forwardable without ever showing busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      is_var <= 1'b0;
      cnt    <= '0;
    end else if (issue_hit) begin
      if (lat == SCORE_LAT_VAR) begin
        busy   <= 1'b1;
        is_var <= 1'b1;
        cnt    <= '0;
      end else begin
        busy   <= (lat != ScoreLat'(1));
        is_var <= 1'b0;
        cnt    <= lat - ScoreLat'(1);
      end
    end else if (clear_hit) begin
      busy   <= 1'b0;
      is_var <= 1'b0;
      cnt    <= '0;
    end else if (busy && !is_var) begin
      cnt <= cnt - ScoreLat'(1);
      if (cnt == ScoreLat'(1)) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/stage_id_scoreboard.sv
// ID-stage register scoreboard: RAW/WAW hazard detection for fixed and variable latency producers.
// Optional macro RV_SCOREBOARD_WB_BYPASS_EN lets a same-cycle writeback clear hide the busy bit.
module stage_id_scoreboard
  import stage_id_scoreboard_pkg::*;
(
  input  logic                  i_clock,
  input  logic                  i_reset,
  stage_id_scoreboard_if.slave  sb
);

  logic [REG_COUNT-1:0] busy;
  logic [REG_COUNT-1:0] busy_cmp;
  logic [REG_COUNT-1:0] clr_dec;
  logic [REG_COUNT-1:0] iss_dec;
  logic                 raw1;
  logic                 raw2;
  logic                 waw;
  logic                 hazard;
  logic                 accept;

  // Duplicate clears from several ports simply OR together.
  always_comb begin
    clr_dec = '0;
    for (int k = 0; k < WB_PORTS; k++) begin
      if (sb.i_wbValid[k]) begin
        clr_dec[sb.i_wbAddr[k]] = 1'b1;
      end
    end
    clr_dec[0] = 1'b0;
  end

`ifdef RV_SCOREBOARD_WB_BYPASS_EN
  assign busy_cmp = busy & ~clr_dec;
`else
  assign busy_cmp = busy;
`endif

  assign raw1   = sb.i_issUseRS1 && (sb.i_issRS1 != '0) && busy_cmp[sb.i_issRS1];
  assign raw2   = sb.i_issUseRS2 && (sb.i_issRS2 != '0) && busy_cmp[sb.i_issRS2];
  assign waw    = (sb.i_issRD != '0) && busy_cmp[sb.i_issRD];
  assign hazard = raw1 || raw2 || waw;
  assign accept = sb.i_issValid && !hazard && !sb.i_stall;

  always_comb begin
    iss_dec = '0;
    if (accept) begin
      iss_dec[sb.i_issRD] = 1'b1;
    end
    iss_dec[0] = 1'b0;
  end

  assign busy[0] = 1'b0;

  for (genvar r = 1; r < REG_COUNT; r++) begin : g_entry
    scoreboard_entry u_entry (
      .clk       (i_clock),
      .rst_n     (i_reset),
      .issue_hit (iss_dec[r]),
      .lat       (sb.i_issLat),
      .clear_hit (clr_dec[r]),
      .busy      (busy[r])
    );
  end

  assign sb.o_hazard    = hazard;
  assign sb.o_issAccept = accept;
  assign sb.o_busyMask  = busy;

endmodule

// File: tb/tb_stage_id_scoreboard.sv
// Directed testbench for stage_id_scoreboard; expectations follow RV_SCOREBOARD_WB_BYPASS_EN.
module tb_stage_id_scoreboard;
  import stage_id_scoreboard_pkg::*;

`ifdef RV_SCOREBOARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  stage_id_scoreboard_if sb ();

  stage_id_scoreboard dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .sb      (sb)
  );

  task automatic idle();
    sb.i_issValid  = 1'b0;
    sb.i_issRS1    = '0;
    sb.i_issRS2    = '0;
    sb.i_issUseRS1 = 1'b0;
    sb.i_issUseRS2 = 1'b0;
    sb.i_issRD     = '0;
    sb.i_issLat    = '0;
    sb.i_stall     = 1'b0;
    sb.i_wbValid   = '0;
    sb.i_wbAddr    = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input RegAddr rd, input ScoreLat lat);
    idle();
    sb.i_issValid = 1'b1;
    sb.i_issRD    = rd;
    sb.i_issLat   = lat;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    sb.i_issRS1 = 5'd5; sb.i_issUseRS1 = 1'b1;
    #1;
    total++; if (sb.o_busyMask !== 32'h0) begin bad++; $display("FAIL rst_busy got=%h want=%h", sb.o_busyMask, 32'h0); end
    total++; if (sb.o_hazard !== 1'b0) begin bad++; $display("FAIL rst_hazard got=%b want=0", sb.o_hazard); end
    total++; if (sb.o_issAccept !== 1'b0) begin bad++; $display("FAIL rst_accept_novalid got=%b want=0", sb.o_issAccept); end
    idle();
  endtask

  task automatic test_load_use();
    issue(5'd5, 3'd0); #1;
    total++; if (sb.o_issAccept !== 1'b1) begin bad++; $display("FAIL lu_prod_accept got=%b want=1", sb.o_issAccept); end
    cyc();
    idle(); sb.i_issValid = 1'b1; sb.i_issRS1 = 5'd5; sb.i_issUseRS1 = 1'b1; #1;
    total++; if (sb.o_busyMask !== 32'h20) begin bad++; $display("FAIL lu_busy got=%h want=%h", sb.o_busyMask, 32'h20); end
    total++; if (sb.o_hazard !== 1'b1) begin bad++; $display("FAIL lu_haz1 got=%b want=1", sb.o_hazard); end
    total++; if (sb.o_issAccept !== 1'b0) begin bad++; $display("FAIL lu_acc1 got=%b want=0", sb.o_issAccept); end
    cyc(); #1;
    total++; if (sb.o_hazard !== 1'b1) begin bad++; $display("FAIL lu_haz2 got=%b want=1", sb.o_hazard); end
    sb.i_wbValid = 2'b01; sb.i_wbAddr[0] = 5'd5; #1;
    total++; if (sb.o_issAccept !== BYP) begin bad++; $display("FAIL lu_wb_cycle_acc got=%b want=%b", sb.o_issAccept, BYP); end
    total++; if (sb.o_hazard !== !BYP) begin bad++; $display("FAIL lu_wb_cycle_haz got=%b want=%b", sb.o_hazard, !BYP); end
    cyc();
    sb.i_wbValid = '0; #1;
    total++; if (sb.o_busyMask !== 32'h0) begin bad++; $display("FAIL lu_busy_after got=%h want=0", sb.o_busyMask); end
    total++; if (sb.o_issAccept !== 1'b1) begin bad++; $display("FAIL lu_acc_after got=%b want=1", sb.o_issAccept); end
    cyc();
    idle();
  endtask

  task automatic test_fixed_lat();
    issue(5'd7, 3'd3); #1;
    total++; if (sb.o_issAccept !== 1'b1) begin bad++; $display("FAIL fx_prod_accept got=%b want=1", sb.o_issAccept); end
    cyc();
    idle(); sb.i_issValid = 1'b1; sb.i_issRS2 = 5'd7; sb.i_issUseRS2 = 1'b1; #1;
    total++; if (sb.o_hazard !== 1'b1) begin bad++; $display("FAIL fx_t1_haz got=%b want=1", sb.o_hazard); end
    total++; if (sb.o_busyMask !== 32'h80) begin bad++; $display("FAIL fx_t1_busy got=%h want=%h", sb.o_busyMask, 32'h80); end
    cyc(); #1;
    total++; if (sb.o_hazard !== 1'b1) begin bad++; $display("FAIL fx_t2_haz got=%b want=1", sb.o_hazard); end
    cyc(); #1;
    total++; if (sb.o_busyMask !== 32'h0) begin bad++; $display("FAIL fx_t3_busy got=%h want=0", sb.o_busyMask); end
    total++; if (sb.o_issAccept !== 1'b1) begin bad++; $display("FAIL fx_t3_acc got=%b want=1", sb.o_issAccept); end
    sb.i_stall = 1'b1; #1;
    total++; if (sb.o_issAccept !== 1'b0) begin bad++; $display("FAIL fx_stall_acc got=%b want=0", sb.o_issAccept); end
    cyc();
    // Latency 1: forwardable to the very next instruction.
    issue(5'd10, 3'd1); #1;
    cyc();
    idle(); sb.i_issValid = 1'b1; sb.i_issRS1 = 5'd10; sb.i_issUseRS1 = 1'b1; #1;
    total++; if (sb.o_hazard !== 1'b0) begin bad++; $display("FAIL fx_lat1_haz got=%b want=0", sb.o_hazard); end
    cyc();
    idle();
  endtask

  task automatic test_x0_unused();
    issue(5'd0, 3'd0); #1;
    cyc();
    idle(); #1;
    total++; if (sb.o_busyMask !== 32'h0) begin bad++; $display("FAIL x0_busy got=%h want=0", sb.o_busyMask); end
    issue(5'd5, 3'd0); #1;
    cyc();
    idle(); sb.i_issValid = 1'b1; sb.i_issRS1 = 5'd5; sb.i_issUseRS1 = 1'b0;
    sb.i_issRS2 = 5'd0; sb.i_issUseRS2 = 1'b1; #1;
    total++; if (sb.o_hazard !== 1'b0) begin bad++; $display("FAIL unused_rs1_haz got=%b want=0", sb.o_hazard); end
    sb.i_issUseRS1 = 1'b1; #1;
    total++; if (sb.o_hazard !== 1'b1) begin bad++; $display("FAIL used_rs1_haz got=%b want=1", sb.o_hazard); end
    idle(); sb.i_wbValid = 2'b10; sb.i_wbAddr[1] = 5'd5;
    cyc();
    idle(); #1;
    total++; if (sb.o_busyMask !== 32'h0) begin bad++; $display("FAIL x0_clear_busy got=%h want=0", sb.o_busyMask); end
  endtask

  task automatic test_waw();
    issue(5'd9, 3'd0); #1;
    cyc();
    issue(5'd9, 3'd0); #1;
    total++; if (sb.o_hazard !== 1'b1) begin bad++; $display("FAIL waw_haz got=%b want=1", sb.o_hazard); end
    sb.i_wbValid = 2'b01; sb.i_wbAddr[0] = 5'd9; #1;
    total++; if (sb.o_issAccept !== BYP) begin bad++; $display("FAIL waw_wb_acc got=%b want=%b", sb.o_issAccept, BYP); end
    cyc();
    sb.i_wbValid = '0; #1;
    total++; if (sb.o_busyMask !== (BYP ? 32'h200 : 32'h0)) begin bad++; $display("FAIL waw_busy9 got=%h want=%h", sb.o_busyMask, (BYP ? 32'h200 : 32'h0)); end
    if (!BYP) begin
      cyc();
    end
    idle(); sb.i_wbValid = 2'b01; sb.i_wbAddr[0] = 5'd9;
    cyc();
    idle(); #1;
    total++; if (sb.o_busyMask !== 32'h0) begin bad++; $display("FAIL waw_final got=%h want=0", sb.o_busyMask); end
  endtask

  task automatic test_dual_wb();
    issue(5'd3, 3'd0); cyc();
    issue(5'd4, 3'd0); cyc();
    idle(); #1;
    total++; if (sb.o_busyMask !== 32'h18) begin bad++; $display("FAIL dwb_busy got=%h want=%h", sb.o_busyMask, 32'h18); end
    sb.i_wbValid = 2'b11; sb.i_wbAddr[0] = 5'd3; sb.i_wbAddr[1] = 5'd4;
    cyc();
    idle(); #1;
    total++; if (sb.o_busyMask !== 32'h0) begin bad++; $display("FAIL dwb_both got=%h want=0", sb.o_busyMask); end
    issue(5'd3, 3'd0); cyc();
    issue(5'd4, 3'd0); cyc();
    idle(); sb.i_wbValid = 2'b11; sb.i_wbAddr[0] = 5'd3; sb.i_wbAddr[1] = 5'd3;
    cyc();
    idle(); #1;
    total++; if (sb.o_busyMask !== 32'h10) begin bad++; $display("FAIL dwb_same got=%h want=%h", sb.o_busyMask, 32'h10); end
    sb.i_wbValid = 2'b01; sb.i_wbAddr[0] = 5'd4;
    cyc();
    idle();
  endtask

  task automatic test_reset_mid();
    for (int r = 8; r < 12; r++) begin
      issue(RegAddr'(r), 3'd0);
      cyc();
    end
    idle(); #1;
    total++; if (sb.o_busyMask !== 32'h0000_0F00) begin bad++; $display("FAIL rm_busy got=%h want=%h", sb.o_busyMask, 32'h0F00); end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    sb.i_issRS1 = 5'd8; sb.i_issUseRS1 = 1'b1; sb.i_issValid = 1'b1; #1;
    total++; if (sb.o_busyMask !== 32'h0) begin bad++; $display("FAIL rm_busy_after got=%h want=0", sb.o_busyMask); end
    total++; if (sb.o_hazard !== 1'b0) begin bad++; $display("FAIL rm_hazard got=%b want=0", sb.o_hazard); end
    idle(); sb.i_wbValid = 2'b01; sb.i_wbAddr[0] = 5'd8;
    cyc();
    issue(5'd8, 3'd0); #1;
    total++; if (sb.o_busyMask !== 32'h0) begin bad++; $display("FAIL rm_stale_wb got=%h want=0", sb.o_busyMask); end
    cyc();
    idle(); #1;
    total++; if (sb.o_busyMask !== 32'h100) begin bad++; $display("FAIL rm_reissue got=%h want=%h", sb.o_busyMask, 32'h100); end
  endtask

  initial begin
    idle();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_fixed_lat();
    test_x0_unused();
    test_waw();
    test_dual_wb();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
